// File: rtl/pipe_reg_skid.sv
// Inter-stage pipeline register with valid/ready handshake, 2-entry skid and synchronous flush.
// Optional stall-cycle counter output enabled by defining PIPE_REG_STALL_CNT_EN.
module pipe_reg_skid #(
  parameter int              DATA_W   = 160,
  parameter int              INSTR_W  = 32,
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] PC_RESET = 32'h00003000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [DATA_W-1:0]  out_data
`ifdef PIPE_REG_STALL_CNT_EN
  ,
  output logic [31:0]        stall_cycles
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  occ_t               state_r, state_s;
  logic               in_ready_r;
  logic               out_valid_r;
  logic [PC_W-1:0]    m_pc_r, m_pc_s;
  logic [INSTR_W-1:0] m_instr_r, m_instr_s;
  logic [DATA_W-1:0]  m_data_r, m_data_s;
  logic [PC_W-1:0]    s_pc_r, s_pc_s;
  logic [INSTR_W-1:0] s_instr_r, s_instr_s;
  logic [DATA_W-1:0]  s_data_r, s_data_s;
  logic               accept_s;
  logic               emit_s;

  assign accept_s  = in_valid & in_ready_r;
  assign emit_s    = out_valid_r & out_ready;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_pc    = m_pc_r;
  assign out_instr = m_instr_r;
  assign out_data  = m_data_r;

  // Next occupancy and storage contents; M is cleared to a nop whenever it goes empty.
  always_comb begin
    state_s   = state_r;
    m_pc_s    = m_pc_r;
    m_instr_s = m_instr_r;
    m_data_s  = m_data_r;
    s_pc_s    = s_pc_r;
    s_instr_s = s_instr_r;
    s_data_s  = s_data_r;
    if (flush) begin
      // Flush beats a same-cycle accept; the incoming entry is discarded.
      state_s   = EMPTY;
      m_pc_s    = PC_RESET;
      m_instr_s = {INSTR_W{1'b0}};
      m_data_s  = {DATA_W{1'b0}};
      s_pc_s    = {PC_W{1'b0}};
      s_instr_s = {INSTR_W{1'b0}};
      s_data_s  = {DATA_W{1'b0}};
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            state_s   = ONE;
            m_pc_s    = in_pc;
            m_instr_s = in_instr;
            m_data_s  = in_data;
          end else begin
            state_s = EMPTY;
          end
        end
        ONE: begin
          if (accept_s && emit_s) begin
            m_pc_s    = in_pc;
            m_instr_s = in_instr;
            m_data_s  = in_data;
          end else if (accept_s) begin
            state_s   = TWO;
            s_pc_s    = in_pc;
            s_instr_s = in_instr;
            s_data_s  = in_data;
          end else if (emit_s) begin
            // PC stays visible so the bubble still carries its position.
            state_s   = EMPTY;
            m_instr_s = {INSTR_W{1'b0}};
            m_data_s  = {DATA_W{1'b0}};
          end else begin
            state_s = ONE;
          end
        end
        TWO: begin
          if (emit_s) begin
            state_s   = ONE;
            m_pc_s    = s_pc_r;
            m_instr_s = s_instr_r;
            m_data_s  = s_data_r;
          end else begin
            state_s = TWO;
          end
        end
        default: begin
          state_s   = EMPTY;
          m_pc_s    = PC_RESET;
          m_instr_s = {INSTR_W{1'b0}};
          m_data_s  = {DATA_W{1'b0}};
        end
      endcase
    end
  end

  // State and storage registers; handshake flags are derived from the next state so they stay registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      m_pc_r      <= PC_RESET;
      m_instr_r   <= {INSTR_W{1'b0}};
      m_data_r    <= {DATA_W{1'b0}};
      s_pc_r      <= {PC_W{1'b0}};
      s_instr_r   <= {INSTR_W{1'b0}};
      s_data_r    <= {DATA_W{1'b0}};
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s != TWO);
      out_valid_r <= (state_s != EMPTY);
      m_pc_r      <= m_pc_s;
      m_instr_r   <= m_instr_s;
      m_data_r    <= m_data_s;
      s_pc_r      <= s_pc_s;
      s_instr_r   <= s_instr_s;
      s_data_r    <= s_data_s;
    end
  end

`ifdef PIPE_REG_STALL_CNT_EN
  logic [31:0] stall_cnt_r;

  assign stall_cycles = stall_cnt_r;

  // Saturating count of cycles where a valid entry is held back by downstream; flush does not clear it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_r <= 32'd0;
    end else if (out_valid_r && !out_ready && (stall_cnt_r != 32'hFFFFFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Directed-vector bench for pipe_reg_skid: reset, streaming, backpressure, flush priority,
// async reset and (with PIPE_REG_STALL_CNT_EN) the stall counter.
module tb_pipe_reg_skid;

  localparam int DATA_W  = 160;
  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  logic               clk;
  logic               reset;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [PC_W-1:0]    in_pc;
  logic [INSTR_W-1:0] in_instr;
  logic [DATA_W-1:0]  in_data;
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    out_pc;
  logic [INSTR_W-1:0] out_instr;
  logic [DATA_W-1:0]  out_data;
`ifdef PIPE_REG_STALL_CNT_EN
  logic [31:0]        stall_cycles;
`endif

  int n_vec;
  int n_bad;

  pipe_reg_skid #(
    .DATA_W  (DATA_W),
    .INSTR_W (INSTR_W),
    .PC_W    (PC_W),
    .PC_RESET(32'h00003000)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_pc    (in_pc),
    .in_instr (in_instr),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc   (out_pc),
    .out_instr(out_instr),
    .out_data (out_data)
`ifdef PIPE_REG_STALL_CNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [PC_W-1:0] pc, input logic [INSTR_W-1:0] ins);
    in_valid = v;
    in_pc    = pc;
    in_instr = ins;
    in_data  = {96'd0, 32'hDA7A0000, pc};
  endtask

  function automatic logic [DATA_W-1:0] dat(input logic [PC_W-1:0] pc);
    return {96'd0, 32'hDA7A0000, pc};
  endfunction

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    reset     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);

    // Reset held three cycles, then released and idled.
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk("rst_valid", 160'(out_valid), 160'd0);
    chk("rst_pc",    160'(out_pc),    160'h3000);
    chk("rst_instr", 160'(out_instr), 160'd0);
    chk("rst_data",  out_data,        160'd0);
    chk("rst_ready", 160'(in_ready),  160'd1);

    // Streaming with downstream always ready: one-cycle latency, in order.
    out_ready = 1'b1;
    drive(1'b1, 32'h3000, 32'h24010001);
    tick();
    chk("s0_valid", 160'(out_valid), 160'd1);
    chk("s0_pc",    160'(out_pc),    160'h3000);
    chk("s0_instr", 160'(out_instr), 160'h24010001);
    chk("s0_ready", 160'(in_ready),  160'd1);
    drive(1'b1, 32'h3004, 32'h24020002);
    tick();
    chk("s1_pc",    160'(out_pc),    160'h3004);
    chk("s1_instr", 160'(out_instr), 160'h24020002);
    chk("s1_ready", 160'(in_ready),  160'd1);
    drive(1'b1, 32'h3008, 32'h24030003);
    tick();
    chk("s2_pc",    160'(out_pc),    160'h3008);
    chk("s2_instr", 160'(out_instr), 160'h24030003);
    chk("s2_data",  out_data,        dat(32'h3008));
    chk("s2_ready", 160'(in_ready),  160'd1);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk("drain_valid", 160'(out_valid), 160'd0);
    chk("drain_instr", 160'(out_instr), 160'd0);
    chk("drain_data",  out_data,        160'd0);
    chk("drain_pc",    160'(out_pc),    160'h3008);

    // Backpressure: fill both entries, then drain A then B.
    out_ready = 1'b0;
    drive(1'b1, 32'h3000, 32'h0000000A);
    tick();
    chk("bp_a_ready", 160'(in_ready), 160'd1);
    chk("bp_a_pc",    160'(out_pc),   160'h3000);
    drive(1'b1, 32'h3004, 32'h0000000B);
    tick();
    chk("bp_two_ready", 160'(in_ready),  160'd0);
    chk("bp_two_pc",    160'(out_pc),    160'h3000);
    chk("bp_two_valid", 160'(out_valid), 160'd1);
    drive(1'b1, 32'h3008, 32'h0000000C);
    tick();
    chk("bp_hold_pc",    160'(out_pc),    160'h3000);
    chk("bp_hold_instr", 160'(out_instr), 160'h0000000A);
    chk("bp_hold_ready", 160'(in_ready),  160'd0);
    drive(1'b0, 32'h0, 32'h0);
    out_ready = 1'b1;
    tick();
    chk("bp_b_pc",    160'(out_pc),    160'h3004);
    chk("bp_b_instr", 160'(out_instr), 160'h0000000B);
    chk("bp_b_data",  out_data,        dat(32'h3004));
    chk("bp_b_ready", 160'(in_ready),  160'd1);
    tick();
    chk("bp_end_valid", 160'(out_valid), 160'd0);
    chk("bp_end_pc",    160'(out_pc),    160'h3004);

    // Flush wins over a simultaneous accept.
    out_ready = 1'b0;
    drive(1'b1, 32'h3010, 32'h00000010);
    tick();
    chk("fl_one_pc", 160'(out_pc), 160'h3010);
    flush = 1'b1;
    drive(1'b1, 32'h3014, 32'h00000014);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk("fl_valid", 160'(out_valid), 160'd0);
    chk("fl_instr", 160'(out_instr), 160'd0);
    chk("fl_pc",    160'(out_pc),    160'h3000);
    chk("fl_ready", 160'(in_ready),  160'd1);
    tick();
    chk("fl_after_valid", 160'(out_valid), 160'd0);
    chk("fl_after_pc",    160'(out_pc),    160'h3000);

    // Async reset from TWO, asserted between edges.
    drive(1'b1, 32'h3020, 32'h00000020);
    tick();
    drive(1'b1, 32'h3024, 32'h00000024);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("ar_two_ready", 160'(in_ready), 160'd0);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_valid", 160'(out_valid), 160'd0);
    chk("ar_pc",    160'(out_pc),    160'h3000);
    chk("ar_instr", 160'(out_instr), 160'd0);
    chk("ar_data",  out_data,        160'd0);
    chk("ar_ready", 160'(in_ready),  160'd1);
    tick();
    reset = 1'b1;
    tick();
    chk("ar_rel_valid", 160'(out_valid), 160'd0);

`ifdef PIPE_REG_STALL_CNT_EN
    // Seven stalled cycles with a valid entry, then a flush with emit leaves the count alone.
    chk("sc_zero", 160'(stall_cycles), 160'd0);
    out_ready = 1'b0;
    drive(1'b1, 32'h3030, 32'h00000030);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    repeat (7) tick();
    chk("sc_seven", 160'(stall_cycles), 160'd7);
    out_ready = 1'b1;
    flush     = 1'b1;
    tick();
    flush     = 1'b0;
    chk("sc_flush",       160'(stall_cycles), 160'd7);
    chk("sc_flush_valid", 160'(out_valid),    160'd0);
    tick();
    chk("sc_idle", 160'(stall_cycles), 160'd7);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_reg_skid.md
Name: pipe_reg_skid

Overview:
- Parametrised successor to the fixed-field inter-stage pipeline registers (D/E/M/W) of the pipelined MIPS CPU.
- Carries PC, instruction and a generic payload bus between adjacent stages under a valid/ready handshake, with a 2-entry skid so in_ready is registered.
- Adds synchronous flush (bubble insertion). Flushed or invalid slots present as nop (instr 0).
- Instantiated once per stage boundary; stall and flush come from the hazard unit.

Parameters:
- DATA_W, 160, payload width (e.g. ALUResult/EXTResult/MemReadData/HI/LO = 5x32).
- INSTR_W, 32, instruction field width.
- PC_W, 32, PC field width.
- PC_RESET, 32'h00003000, PC value presented on reset and after flush.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous flush; drops all held entries.
- in_valid  input  1  upstream entry valid.
- in_ready  output  1  stage can accept; registered.
- in_pc  input  PC_W  upstream PC.
- in_instr  input  INSTR_W  upstream instruction.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  downstream entry valid.
- out_ready  input  1  downstream accepts.
- out_pc  output  PC_W  held PC.
- out_instr  output  INSTR_W  held instruction; 0 when out_valid=0.
- out_data  output  DATA_W  held payload; 0 when out_valid=0.

Behaviour:
- Storage: main register M (drives outputs) and skid register S. Occupancy states EMPTY, ONE (M full), TWO (M and S full).
- Reset (reset=0, async):
  - State EMPTY; in_ready=1; out_valid=0; out_pc=PC_RESET; out_instr=0; out_data=0.
  - S cleared.
  - Deassertion is synchronised externally; the block samples on the next clk edge.
- Transfers: accept = in_valid & in_ready; emit = out_valid & out_ready.
- in_ready = (state != TWO), registered.
- Latency: 1 cycle from accept to out_valid when EMPTY.
- EMPTY:
  - accept -> load M, go ONE.
  - Otherwise hold.
- ONE:
  - accept & emit -> load M with input, stay ONE.
  - accept & !emit -> load S, go TWO; in_ready drops next cycle.
  - !accept & emit -> go EMPTY; outputs return to nop with PC held.
  - Neither -> hold.
- TWO (in_ready=0, no accept possible):
  - emit -> M<=S, go ONE.
  - Otherwise hold all.
- Ordering: strict FIFO. No entry is dropped or duplicated except by flush.
- Flush (sampled high at edge):
  - Next state EMPTY; out_valid=0; out_instr=0; out_data=0; out_pc=PC_RESET.
  - in_ready=1 next cycle.
  - Flush wins over simultaneous accept: the accepted entry is discarded, not loaded.
  - An emit in the same cycle still completes downstream (downstream sampled it).
- Outputs update only on clk edges or async reset; no combinational in->out path.
- Widths are used as given; no truncation or extension inside the block.

Optional Feature:
- Macro PIPE_REG_STALL_CNT_EN.
- Defined:
  - Extra output port stall_cycles, 32 bits.
  - Counts cycles with out_valid=1 & out_ready=0; saturates at 32'hFFFFFFFF.
  - Cleared by reset, not by flush.
- Undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset then idle: reset low 3 cycles, release -> out_valid=0, out_pc=32'h00003000, out_instr=0, in_ready=1.
- Streaming, out_ready=1:
  - Stimulus: in_valid=1 with pc 0x3000, 0x3004, 0x3008 and instr 0x24010001, 0x24020002, 0x24030003 on consecutive cycles.
  - Required: each appears on out_* exactly 1 cycle later, in order; in_ready stays 1.
- Backpressure fill:
  - Stimulus: out_ready=0, push A (pc 0x3000), then B (pc 0x3004).
  - Required: state TWO; in_ready=0 the cycle after B; out_pc stays 0x3000.
  - Then raise out_ready -> A emitted, then B; in_ready returns to 1 after A leaves.
- Flush priority:
  - Stimulus: in state ONE holding pc 0x3010, assert flush and in_valid with pc 0x3014 in the same cycle.
  - Required: next cycle out_valid=0, out_instr=0, out_pc=0x3000; 0x3014 never appears.
- Async reset mid-operation: in TWO, pull reset low between edges -> outputs reach reset values immediately, without waiting for a clk edge.
- PIPE_REG_STALL_CNT_EN: hold a valid entry with out_ready=0 for 7 cycles -> stall_cycles=7; flush leaves it at 7.
